// File: rtl/micro_op_serializer_pkg.sv
// Shared types for the micro-op serializer: group geometry, pending-count type,
// serializer state and the opaque micro-op payload record.
package micro_op_serializer_pkg;

    localparam int DEFAULT_DECODE_WIDTH       = 2;
    localparam int DEFAULT_MICRO_OP_MAX_NUM   = 3;
    localparam int GROUP_WIDTH                = DEFAULT_MICRO_OP_MAX_NUM * DEFAULT_DECODE_WIDTH;
    localparam int ALL_DECODED_MICRO_OP_WIDTH = $clog2(GROUP_WIDTH);

    typedef logic [ALL_DECODED_MICRO_OP_WIDTH:0] SerializerCount;

    typedef enum logic {
        SER_EMPTY = 1'b0,
        SER_DRAIN = 1'b1
    } ser_state_e;

    // Payload is carried through untouched; the serializer never inspects it.
    typedef struct packed {
        logic [7:0] opcode;
        logic [3:0] dst;
        logic       mid;
        logic       last;
        logic       split;
    } op_info_t;

endpackage

// File: rtl/micro_op_serializer_lane_picker.sv
// micro_op_lane_picker: combinational selector returning the slot indices of the
// first DECODE_WIDTH set bits of a mask, lowest index first.
module micro_op_lane_picker #(
    parameter int DECODE_WIDTH = 2,
    parameter int GROUP_WIDTH  = 6,
    parameter int IDX_WIDTH    = $clog2(GROUP_WIDTH)
) (
    input  logic [GROUP_WIDTH-1:0]                  mask_i,
    output logic [DECODE_WIDTH-1:0][IDX_WIDTH-1:0]  lane_idx_o,
    output logic [DECODE_WIDTH-1:0]                 lane_valid_o
);

    // Walk the mask once; the running set-bit count decides which lane a hit fills.
    always_comb begin
        int cnt;
        cnt          = 0;
        lane_idx_o   = '0;
        lane_valid_o = '0;
        for (int i = 0; i < GROUP_WIDTH; i++) begin
            for (int k = 0; k < DECODE_WIDTH; k++) begin
                if (mask_i[i] && (cnt == k)) begin
                    lane_idx_o[k]   = IDX_WIDTH'(i);
                    lane_valid_o[k] = 1'b1;
                end else begin
                    lane_idx_o[k]   = lane_idx_o[k];
                    lane_valid_o[k] = lane_valid_o[k];
                end
            end
            if (mask_i[i]) begin
                cnt = cnt + 1;
            end else begin
                cnt = cnt;
            end
        end
    end

endmodule

// File: rtl/micro_op_serializer.sv
// Buffers one decoded micro-op group and emits it DECODE_WIDTH lanes per cycle in
// program order, accepting the next group in the same cycle the last lanes drain.
module micro_op_serializer
    import micro_op_serializer_pkg::*;
#(
    parameter int DECODE_WIDTH     = DEFAULT_DECODE_WIDTH,
    parameter int MICRO_OP_MAX_NUM = DEFAULT_MICRO_OP_MAX_NUM,
    localparam int GROUP_WIDTH     = MICRO_OP_MAX_NUM * DECODE_WIDTH
) (
    input  logic                              clk,
    input  logic                              rstN,
    input  logic                              flush,
    input  logic                              inValid,
    input  logic [GROUP_WIDTH-1:0]            inSlotValid,
    input  op_info_t [GROUP_WIDTH-1:0]        inOps,
    output logic                              inReady,
    input  logic                              stall,
    output logic [DECODE_WIDTH-1:0]           outValid,
    output op_info_t [DECODE_WIDTH-1:0]       outOps
);

    localparam int IW = $clog2(GROUP_WIDTH);
    localparam int CW = IW + 1;

    op_info_t [GROUP_WIDTH-1:0]        slots_q, slots_d;
    logic [GROUP_WIDTH-1:0]            pend_mask_q, pend_mask_d;
    logic [CW-1:0]                     pend_cnt_q, pend_cnt_d;
    logic [DECODE_WIDTH-1:0][IW-1:0]   lane_idx_s;
    logic [DECODE_WIDTH-1:0]           lane_valid_s;
    logic [GROUP_WIDTH-1:0]            emit_mask_s;
    logic [CW-1:0]                     emit_cnt_s;
    logic [CW-1:0]                     in_cnt_s;
    ser_state_e                        state_s;
    logic                              in_ready_s;

    micro_op_lane_picker #(
        .DECODE_WIDTH (DECODE_WIDTH),
        .GROUP_WIDTH  (GROUP_WIDTH),
        .IDX_WIDTH    (IW)
    ) u_picker (
        .mask_i       (pend_mask_q),
        .lane_idx_o   (lane_idx_s),
        .lane_valid_o (lane_valid_s)
    );

    // Output lanes, emitted-slot mask and the acceptance condition.
    always_comb begin
        outValid    = lane_valid_s;
        emit_mask_s = '0;
        emit_cnt_s  = '0;
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            outOps[k] = slots_q[lane_idx_s[k]];
            if (lane_valid_s[k]) begin
                emit_mask_s[lane_idx_s[k]] = 1'b1;
                emit_cnt_s                 = emit_cnt_s + CW'(1);
            end else begin
                emit_cnt_s = emit_cnt_s;
            end
        end
        if (pend_mask_q != '0) begin
            state_s = SER_DRAIN;
        end else begin
            state_s = SER_EMPTY;
        end
        // Zero-bubble overlap: a group may load while the final lanes drain.
        in_ready_s = rstN && !flush &&
                     ((state_s == SER_EMPTY) ||
                      (!stall && (pend_cnt_q <= CW'(DECODE_WIDTH))));
        inReady    = in_ready_s;
    end

    // Next-state: flush beats load, load beats drain, stall holds everything.
    always_comb begin
        slots_d     = slots_q;
        pend_mask_d = pend_mask_q;
        pend_cnt_d  = pend_cnt_q;
        in_cnt_s    = '0;
        for (int i = 0; i < GROUP_WIDTH; i++) begin
            in_cnt_s = in_cnt_s + CW'(inSlotValid[i]);
        end
        if (flush) begin
            pend_mask_d = '0;
            pend_cnt_d  = '0;
        end else if (inValid && in_ready_s) begin
            slots_d     = inOps;
            pend_mask_d = inSlotValid;
            pend_cnt_d  = in_cnt_s;
        end else if (!stall) begin
            pend_mask_d = pend_mask_q & ~emit_mask_s;
            pend_cnt_d  = pend_cnt_q - emit_cnt_s;
        end else begin
            pend_mask_d = pend_mask_q;
            pend_cnt_d  = pend_cnt_q;
        end
    end

    // Pending bookkeeping; reset drops any partially drained group.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pend_mask_q <= '0;
            pend_cnt_q  <= '0;
        end else begin
            pend_mask_q <= pend_mask_d;
            pend_cnt_q  <= pend_cnt_d;
        end
    end

    // Payload storage is qualified by the pending mask, so it carries no reset.
    always_ff @(posedge clk) begin
        slots_q <= slots_d;
    end

endmodule
